// File: rtl/ntt_pkg.sv
// Shared FSM encoding, default constants and the modpow helper for ntt_stream.
// Defaults target N=64 over Q = 2^64 - 2^32 + 1, where 8 is a primitive 64th root of unity.
package ntt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_CALC  = 2'd2,
        ST_DRAIN = 2'd3
    } ntt_state_e;

    localparam logic [63:0] NTT_Q         = 64'hFFFF_FFFF_0000_0001;
    localparam logic [63:0] NTT_OMEGA     = 64'd8;
    // 8^-1 and 64^-1 follow from 2^96 == -1 in this field
    localparam logic [63:0] NTT_OMEGA_INV = 64'hDFFF_FFFF_2000_0001;
    localparam logic [63:0] NTT_N_INV     = 64'hFBFF_FFFF_0400_0001;

    function automatic logic [63:0] modpow(input logic [63:0] base,
                                           input logic [63:0] expo,
                                           input logic [63:0] m);
        logic [127:0] r;
        logic [127:0] b;
        logic [127:0] mm;
        logic [63:0]  e;
        mm = 128'(m);
        r  = 128'd1 % mm;
        b  = 128'(base) % mm;
        e  = expo;
        while (e != 64'd0) begin
            if (e[0]) r = (r * b) % mm;
            b = (b * b) % mm;
            e = e >> 1;
        end
        return r[63:0];
    endfunction

endpackage

// File: rtl/ntt_stream_if.sv
// Handshake bundle for ntt_stream: load port, result port and status.
// NTT_INVERSE_EN adds the inv select sampled on start.
interface ntt_stream_if #(
    parameter int unsigned DW = 64,
    parameter int unsigned IW = 6
);
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_index;
    logic          busy;
    logic          done;

`ifdef NTT_INVERSE_EN
    logic          inv;

    modport master (output start, inv, in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_index, busy, done);
    modport slave  (input  start, inv, in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_index, busy, done);
`else
    modport master (output start, in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_index, busy, done);
    modport slave  (input  start, in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_index, busy, done);
`endif

endinterface

// File: rtl/ntt_modmul.sv
// Combinational modular multiply: y = a*b mod Q, product formed at full 2*DW width.
module ntt_modmul #(
    parameter int unsigned   DW = 64,
    parameter logic [DW-1:0] Q  = '1
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    output logic [DW-1:0] y
);

    assign y = DW'(((2*DW)'(a) * (2*DW)'(b)) % (2*DW)'(Q));

endmodule

// File: rtl/ntt_stream.sv
// Streaming NTT: load N samples, compute L output bins per pass by direct MAC, drain in order.
// Optional NTT_INVERSE_EN adds an inv input selecting OMEGA_INV and N_INV output scaling.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_LOAD  | accepting x[0..N-1] into the buffer
// ST_CALC  | N MAC cycles for lanes k = base..base+L-1
// ST_DRAIN | emitting the L lane results of the current pass
module ntt_stream
    import ntt_pkg::*;
#(
    parameter int unsigned   N         = 64,
    parameter int unsigned   L         = 8,
    parameter int unsigned   DW        = 64,
    parameter logic [DW-1:0] Q         = DW'(NTT_Q),
    parameter logic [DW-1:0] OMEGA     = DW'(NTT_OMEGA)
`ifdef NTT_INVERSE_EN
    ,
    parameter logic [DW-1:0] OMEGA_INV = DW'(NTT_OMEGA_INV),
    parameter logic [DW-1:0] N_INV     = DW'(NTT_N_INV)
`endif
) (
    input logic         clk,
    input logic         rst,
    ntt_stream_if.slave bus
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned LW = (L > 1) ? $clog2(L) : 1;

    ntt_state_e    state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] base_q, base_d;
    logic [LW-1:0] lane_q, lane_d;
    logic          done_q, done_d;
    logic [DW-1:0] acc_q [L];
    logic [DW-1:0] acc_d [L];
    logic [DW-1:0] tw_q  [L];
    logic [DW-1:0] tw_d  [L];
    logic [DW-1:0] acc_nxt [L];
    logic [DW-1:0] tw_nxt  [L];
    logic [DW-1:0] step    [L];
    logic [DW-1:0] step_tab [N];
    logic [DW-1:0] xbuf_q [N];
    logic [DW-1:0] x_cur, acc_sel, res;
    logic          buf_we, pass_init, calc_step, drain;
`ifdef NTT_INVERSE_EN
    logic          inv_q, inv_d;
`endif

    // OMEGA^k for every bin, folded to constants at elaboration
    for (genvar k = 0; k < N; k++) begin : g_step
        localparam logic [DW-1:0] FWD = DW'(modpow(64'(OMEGA), 64'(k), 64'(Q)));
`ifdef NTT_INVERSE_EN
        localparam logic [DW-1:0] INV = DW'(modpow(64'(OMEGA_INV), 64'(k), 64'(Q)));
        assign step_tab[k] = inv_q ? INV : FWD;
`else
        assign step_tab[k] = FWD;
`endif
    end

    assign x_cur = xbuf_q[cnt_q];

    for (genvar l = 0; l < L; l++) begin : g_lane
        logic [DW-1:0] prod;
        logic [DW:0]   sum;
        assign step[l] = step_tab[base_q + IW'(l)];
        ntt_modmul #(.DW(DW), .Q(Q)) u_mac (.a(x_cur),   .b(tw_q[l]), .y(prod));
        ntt_modmul #(.DW(DW), .Q(Q)) u_tw  (.a(tw_q[l]), .b(step[l]), .y(tw_nxt[l]));
        assign sum        = {1'b0, acc_q[l]} + {1'b0, prod};
        assign acc_nxt[l] = (sum >= {1'b0, Q}) ? DW'(sum - {1'b0, Q}) : DW'(sum);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        lane_d    = lane_q;
        done_d    = 1'b0;
        buf_we    = 1'b0;
        pass_init = 1'b0;
        calc_step = 1'b0;
`ifdef NTT_INVERSE_EN
        inv_d     = inv_q;
`endif
        case (state_q)
            ST_IDLE: if (bus.start) begin
                state_d = ST_LOAD;
                cnt_d   = '0;
`ifdef NTT_INVERSE_EN
                inv_d   = bus.inv;
`endif
            end
            ST_LOAD: if (bus.in_valid) begin
                buf_we = 1'b1;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == IW'(N - 1)) begin
                    state_d   = ST_CALC;
                    base_d    = '0;
                    pass_init = 1'b1;
                end
            end
            ST_CALC: begin
                calc_step = 1'b1;
                cnt_d     = cnt_q + 1'b1;
                if (cnt_q == IW'(N - 1)) begin
                    state_d = ST_DRAIN;
                    lane_d  = '0;
                end
            end
            ST_DRAIN: if (bus.out_ready) begin
                lane_d = lane_q + 1'b1;
                if (lane_q == LW'(L - 1)) begin
                    lane_d = '0;
                    if (base_q == IW'(N - L)) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_CALC;
                        base_d    = base_q + IW'(L);
                        pass_init = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        acc_d = acc_q;
        tw_d  = tw_q;
        for (int l = 0; l < L; l++) begin
            if (pass_init) begin
                acc_d[l] = '0;
                tw_d[l]  = DW'(1);
            end else if (calc_step) begin
                acc_d[l] = acc_nxt[l];
                tw_d[l]  = tw_nxt[l];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            lane_q  <= '0;
            done_q  <= 1'b0;
            acc_q   <= '{default: '0};
            tw_q    <= '{default: '0};
`ifdef NTT_INVERSE_EN
            inv_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            lane_q  <= lane_d;
            done_q  <= done_d;
            acc_q   <= acc_d;
            tw_q    <= tw_d;
`ifdef NTT_INVERSE_EN
            inv_q   <= inv_d;
`endif
        end
    end

    // Sample memory holds no control state, so it is left out of reset
    always_ff @(posedge clk) begin
        if (buf_we) xbuf_q[cnt_q] <= DW'(bus.in_data % Q);
    end

    assign acc_sel = acc_q[lane_q];
`ifdef NTT_INVERSE_EN
    logic [DW-1:0] acc_scaled;
    ntt_modmul #(.DW(DW), .Q(Q)) u_scale (.a(acc_sel), .b(N_INV), .y(acc_scaled));
    assign res = inv_q ? acc_scaled : acc_sel;
`else
    assign res = acc_sel;
`endif

    assign drain         = (state_q == ST_DRAIN);
    assign bus.in_ready  = (state_q == ST_LOAD);
    assign bus.out_valid = drain;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;
    assign bus.out_data  = drain ? res : '0;
    assign bus.out_index = drain ? base_q + IW'(lane_q) : '0;

endmodule

// File: doc/ntt_stream.md
NTT_STREAM -- requirements
Module: ntt_stream

Interface
REQ-001 Parameter N, default 64, meaning transform length in points (power of two, >=4).
REQ-002 Parameter L, default 8, meaning parallel lanes (power of two, divides N).
REQ-003 Parameter DW, default 64, meaning data width in bits.
REQ-004 Parameter Q, default 64'hFFFF_FFFF_0000_0001, meaning prime modulus (<2^DW).
REQ-005 Parameter OMEGA, default package constant, meaning primitive Nth root of unity mod Q.
REQ-006 clk  input  1  sole clock; all state on rising edge.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 start  input  1  begin a transform when IDLE.
REQ-009 in_valid/in_ready  input/output  1/1  load handshake for x.
REQ-010 in_data  input  DW  sample x[j], natural order.
REQ-011 out_valid/out_ready  output/input  1/1  result handshake.
REQ-012 out_data  output  DW  result y[k].
REQ-013 out_index  output  clog2(N)  k of out_data.
REQ-014 busy  output  1  high in any state except IDLE.
REQ-015 done  output  1  one-cycle pulse after last result accepted.

Function
REQ-016 The block SHALL compute y[k] = sum over j of x[j]*OMEGA^(k*j) mod Q, for k = 0..N-1.
REQ-017 FSM states IDLE, LOAD, CALC, DRAIN; IDLE->LOAD on start; LOAD->CALC after N accepted beats; CALC->DRAIN after N cycles; DRAIN->CALC after L accepted beats if passes remain, else ->IDLE.
REQ-018 in_ready high only in LOAD; beat j stored to internal buffer entry j; in_data >= Q reduced mod Q on store.
REQ-019 Pass p (0..N/L-1) SHALL compute lanes k = p*L+l; each lane holds acc and twiddle tw, both cleared/set to 1 on pass entry.
REQ-020 Each CALC cycle j: acc[l] <= (acc[l] + x[j]*tw[l]) mod Q; tw[l] <= tw[l]*OMEGA^k mod Q; exactly N cycles per pass.
REQ-021 Products formed at 2*DW bits and fully reduced; additions use conditional subtract of Q; all stored values < Q.
REQ-022 DRAIN emits lanes in increasing k; out_data/out_index SHALL hold stable while out_valid && !out_ready.
REQ-023 done pulses the cycle after the final handshake; busy falls the same cycle.
REQ-024 start while busy SHALL be ignored; in_valid outside LOAD ignored.
REQ-025 L == N SHALL yield one pass; minimum total latency N + N*N/L + N cycles with out_ready held high.

Reset
REQ-026 On rst low, immediately: state IDLE, in_ready 0, out_valid 0, out_data 0, out_index 0, busy 0, done 0, counters 0.
REQ-027 Reset mid-operation SHALL abandon the transform; no partial result emitted after release; buffer contents need not clear.

Configuration
REQ-028 With NTT_INVERSE_EN defined: input port inv (1 bit) sampled on start; inv=1 uses OMEGA_INV and scales each y by N_INV mod Q before output.
REQ-029 Without NTT_INVERSE_EN: no inv port; forward transform only; no scaling logic.

Structure
REQ-030 Package ntt_pkg SHALL hold state enum, default Q, OMEGA, OMEGA_INV, N_INV, and constant function modpow used for per-lane step twiddles.
REQ-031 Sub-module ntt_modmul (DW-bit a*b mod Q, combinational) SHALL be instantiated per lane for MAC and twiddle update.

Verification
REQ-032 N=8, L=4, Q=17, OMEGA=2: x = {1,0,0,0,0,0,0,0} -> y all 1, out_index 0..7, one done pulse.
REQ-033 Same config: x all 1 -> y[0]=8, y[1..7]=0.
REQ-034 Same config: x = {0,1,0,...} -> y[k] = 2^k mod 17 = {1,2,4,8,16,15,13,9}.
REQ-035 NTT_INVERSE_EN, N_INV=15: forward of {3,1,4,1,5,9,2,6}, fed back with inv=1 -> original sequence.
REQ-036 out_ready toggled randomly -> out_data/out_index stable while stalled, no lost or duplicated k.
REQ-037 rst pulsed during CALC pass 1, then fresh delta transform -> outputs zero during reset, correct all-1 result afterwards.
